// File: rtl/bus_arbiter_rr.sv
// N-master / M-slave single-outstanding bus arbiter with round-robin or fixed priority,
// table-driven slave decode, response timeout and error responses.
module bus_arbiter_rr #(
  parameter int unsigned MASTERS     = 2,
  parameter int unsigned SLAVES      = 2,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned BUS_BYTES   = BUS_WIDTH / 8,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [SLAVES-1:0][ADDR_BITS-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES-1:0][ADDR_BITS-1:0] SLAVE_MASK = '0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [MASTERS-1:0]                  req_i,
  input  logic [MASTERS-1:0][ADDR_BITS-1:0]   addr_i,
  input  logic [MASTERS-1:0][BUS_WIDTH-1:0]   wdata_i,
  input  logic [MASTERS-1:0]                  we_i,
  input  logic [MASTERS-1:0][BUS_BYTES-1:0]   be_i,
  output logic [MASTERS-1:0]                  gnt_o,
  output logic [MASTERS-1:0]                  rvalid_o,
  output logic [MASTERS-1:0]                  err_o,
  output logic [BUS_WIDTH-1:0]                rdata_o,
  output logic [SLAVES-1:0]                   sel_o,
  output logic [ADDR_BITS-1:0]                addr_o,
  output logic [BUS_WIDTH-1:0]                wdata_o,
  output logic                                we_o,
  output logic [BUS_BYTES-1:0]                be_o,
  input  logic [SLAVES-1:0][BUS_WIDTH-1:0]    rdata_i,
  input  logic [SLAVES-1:0]                   ack_i
);

  localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned SW = MW + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 we;
    logic [BUS_BYTES-1:0] be;
  } req_t;

  state_e               state_q, state_d;
  logic [MW-1:0]        ptr_q, ptr_d, own_q, own_d;
  req_t                 lat_q, lat_d;
  logic [TW-1:0]        cnt_q, cnt_d;

  logic [MW-1:0]        win, start, ptr_nxt;
  logic [SW-1:0]        idx, ptr_sum;
  logic                 found, any_req;
  logic [SLAVES-1:0]    hit_oh;
  logic                 hit, ack_hit, timeout_hit;
  logic [BUS_WIDTH-1:0] rsel;

  logic [MASTERS-1:0]   gnt_d, rvalid_d, err_d;
  logic [BUS_WIDTH-1:0] rdata_d, wdata_d;
  logic [SLAVES-1:0]    sel_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic                 we_d;
  logic [BUS_BYTES-1:0] be_d;

  // Arbitration: first requester at or after the start index, wrapping
  always_comb begin
    win     = '0;
    found   = 1'b0;
    idx     = '0;
    start   = (ROUND_ROBIN != 0) ? ptr_q : '0;
    any_req = |req_i;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      idx = SW'(start) + SW'(i);
      if (idx >= SW'(MASTERS)) idx = idx - SW'(MASTERS);
      if (!found && req_i[idx[MW-1:0]]) begin
        found = 1'b1;
        win   = idx[MW-1:0];
      end
    end
    ptr_sum = SW'(win) + SW'(1);
    ptr_nxt = (ptr_sum >= SW'(MASTERS)) ? '0 : ptr_sum[MW-1:0];
  end

  // Address decode (lowest-index hit wins) and selected-slave response
  always_comb begin
    hit_oh = '0;
    hit    = 1'b0;
    rsel   = '0;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      if (!hit && ((lat_q.addr & SLAVE_MASK[s]) == SLAVE_BASE[s])) begin
        hit_oh[s] = 1'b1;
        hit       = 1'b1;
      end
      if (sel_o[s]) rsel = rsel | rdata_i[s];
    end
    ack_hit     = |(ack_i & sel_o);
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_DECODE;
      S_DECODE: state_d = hit ? S_WAIT : S_RESP;
      S_WAIT:   if (ack_hit || timeout_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; ack takes precedence over timeout
  always_comb begin
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = '0;
    sel_d    = sel_o;
    addr_d   = addr_o;
    wdata_d  = wdata_o;
    we_d     = we_o;
    be_d     = be_o;
    ptr_d    = ptr_q;
    own_d    = own_q;
    lat_d    = lat_q;
    cnt_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d[win]  = 1'b1;
          own_d       = win;
          lat_d.addr  = addr_i[win];
          lat_d.wdata = wdata_i[win];
          lat_d.we    = we_i[win];
          lat_d.be    = be_i[win];
          if (ROUND_ROBIN != 0) ptr_d = ptr_nxt;
        end
      end
      S_DECODE: begin
        if (hit) begin
          sel_d   = hit_oh;
          addr_d  = lat_q.addr;
          wdata_d = lat_q.we ? lat_q.wdata : '0;
          we_d    = lat_q.we;
          be_d    = lat_q.be;
        end else begin
          rvalid_d[own_q] = 1'b1;
          err_d[own_q]    = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (ack_hit || timeout_hit) begin
          sel_d           = '0;
          addr_d          = '0;
          wdata_d         = '0;
          we_d            = 1'b0;
          be_d            = '0;
          rvalid_d[own_q] = 1'b1;
          if (ack_hit) rdata_d = lat_q.we ? '0 : rsel;
          else         err_d[own_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      own_q    <= '0;
      lat_q    <= '0;
      cnt_q    <= '0;
      gnt_o    <= '0;
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
      sel_o    <= '0;
      addr_o   <= '0;
      wdata_o  <= '0;
      we_o     <= 1'b0;
      be_o     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      gnt_o    <= gnt_d;
      rvalid_o <= rvalid_d;
      err_o    <= err_d;
      rdata_o  <= rdata_d;
      sel_o    <= sel_d;
      addr_o   <= addr_d;
      wdata_o  <= wdata_d;
      we_o     <= we_d;
      be_o     <= be_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus randomized traffic against a
// transaction-level reference model (arbitration order, decode table, timeout rule).
module tb_bus_arbiter_rr;

  localparam int unsigned NM  = 2;
  localparam int unsigned NS  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned TMO = 8;
  localparam logic [NS-1:0][AW-1:0] BASE = {32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000};

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NM-1:0]          req_i;
  logic [NM-1:0][AW-1:0]  addr_i;
  logic [NM-1:0][DW-1:0]  wdata_i;
  logic [NM-1:0]          we_i;
  logic [NM-1:0][BW-1:0]  be_i;
  logic [NS-1:0][DW-1:0]  rdata_i;
  logic [NS-1:0]          ack_i;

  logic [NM-1:0] gnt_o, rvalid_o, err_o;
  logic [DW-1:0] rdata_o, wdata_o;
  logic [NS-1:0] sel_o;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic [BW-1:0] be_o;

  logic [NM-1:0] fx_gnt_o, fx_rvalid_o, fx_err_o;
  logic [DW-1:0] fx_rdata_o, fx_wdata_o;
  logic [NS-1:0] fx_sel_o;
  logic [AW-1:0] fx_addr_o;
  logic          fx_we_o;
  logic [BW-1:0] fx_be_o;

  int n_chk, n_pass, m_ptr;

  always #5 clk_i = ~clk_i;

  bus_arbiter_rr #(.MASTERS(NM), .SLAVES(NS), .ADDR_BITS(AW), .BUS_WIDTH(DW), .BUS_BYTES(BW),
                   .ROUND_ROBIN(1), .TIMEOUT(TMO), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .rdata_o(rdata_o), .sel_o(sel_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
    .be_o(be_o), .rdata_i(rdata_i), .ack_i(ack_i));

  bus_arbiter_rr #(.MASTERS(NM), .SLAVES(NS), .ADDR_BITS(AW), .BUS_WIDTH(DW), .BUS_BYTES(BW),
                   .ROUND_ROBIN(0), .TIMEOUT(TMO), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut_fx (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .be_i(be_i), .gnt_o(fx_gnt_o), .rvalid_o(fx_rvalid_o), .err_o(fx_err_o),
    .rdata_o(fx_rdata_o), .sel_o(fx_sel_o), .addr_o(fx_addr_o), .wdata_o(fx_wdata_o),
    .we_o(fx_we_o), .be_o(fx_be_o), .rdata_i(rdata_i), .ack_i(ack_i));

  // Reference model: winner by scanning from ptr (or 0) and slave by table lookup
  function automatic int model_win(input logic [NM-1:0] req, input int ptr, input bit rr);
    for (int k = 0; k < NM; k++) begin
      int m;
      m = rr ? (ptr + k) % NM : k;
      if (req[m]) return m;
    end
    return -1;
  endfunction

  function automatic int model_slave(input logic [AW-1:0] a);
    for (int s = 0; s < NS; s++)
      if ((a & MASK[s]) == BASE[s]) return s;
    return -1;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return (i < 0) ? 2'b00 : 2'(1 << i);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    req_i[m] = 1'b1; addr_i[m] = a; we_i[m] = we; wdata_i[m] = wd; be_i[m] = be;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_chk++;
    if ({gnt_o, rvalid_o, err_o, sel_o, we_o} !== '0)
      $display("FAIL reset_ctrl got %b exp 0", {gnt_o, rvalid_o, err_o, sel_o, we_o});
    else n_pass++;
    n_chk++;
    if ({rdata_o, addr_o, wdata_o, be_o} !== '0)
      $display("FAIL reset_bus got %h exp 0", {rdata_o, addr_o, wdata_o, be_o});
    else n_pass++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_rr();
    logic [1:0] gm[$], gf[$];
    logic [1:0] e, g;
    bit multi = 0;
    set_req(0, 32'h100, 1'b1, 32'h1111_0000, 4'hF);
    set_req(1, 32'h104, 1'b1, 32'h2222_0000, 4'h3);
    ack_i = 2'b11;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (gnt_o != 0) gm.push_back(gnt_o);
      if (fx_gnt_o != 0) gf.push_back(fx_gnt_o);
      if ($countones(gnt_o) > 1 || $countones(fx_gnt_o) > 1) multi = 1;
    end
    req_i = '0;
    tick(); tick(); tick(); tick();
    ack_i = '0;
    n_chk++;
    if (gm.size() != 6 || gf.size() != 6)
      $display("FAIL rr_count got %0d/%0d exp 6/6", gm.size(), gf.size());
    else n_pass++;
    n_chk++;
    if (multi) $display("FAIL rr_onehot got multi-hot exp one-hot"); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = model_win(2'b11, m_ptr, 1'b1);
      m_ptr = (w + 1) % NM;
      e = oh(w);
      g = (k < gm.size()) ? gm[k] : 2'b00;
      n_chk++;
      if (g !== e) $display("FAIL rr_grant%0d got %b exp %b", k, g, e); else n_pass++;
      e = oh(model_win(2'b11, 0, 1'b0));
      g = (k < gf.size()) ? gf[k] : 2'b00;
      n_chk++;
      if (g !== e) $display("FAIL fixed_grant%0d got %b exp %b", k, g, e); else n_pass++;
    end
  endtask

  task automatic test_single_read();
    set_req(0, 32'h100, 1'b0, 32'h5555_AAAA, 4'hF);
    rdata_i[0] = 32'hDEAD_BEEF;
    tick();
    n_chk++;
    if (gnt_o !== 2'b01) $display("FAIL rd_gnt got %b exp 01", gnt_o); else n_pass++;
    m_ptr = (model_win(2'b01, m_ptr, 1'b1) + 1) % NM;
    req_i[0] = 1'b0;
    tick();
    n_chk++;
    if ({sel_o, addr_o, wdata_o, we_o} !== {2'b01, 32'h100, 32'h0, 1'b0})
      $display("FAIL rd_sel got sel %b addr %h wd %h we %b exp 01/100/0/0", sel_o, addr_o, wdata_o, we_o);
    else n_pass++;
    ack_i[0] = 1'b1;
    tick();
    ack_i = '0;
    n_chk++;
    if ({rvalid_o, err_o, rdata_o, sel_o} !== {2'b01, 2'b00, 32'hDEAD_BEEF, 2'b00})
      $display("FAIL rd_resp got rv %b err %b rd %h sel %b exp 01/00/deadbeef/00", rvalid_o, err_o, rdata_o, sel_o);
    else n_pass++;
    tick();
    n_chk++;
    if (rvalid_o !== 2'b00) $display("FAIL rd_pulse got %b exp 00", rvalid_o); else n_pass++;
  endtask

  task automatic test_miss();
    bit seen_sel = 0;
    set_req(0, 32'hF000_0000, 1'b0, 32'h0, 4'hF);
    rdata_i = {32'h7777_7777, 32'h6666_6666};
    ack_i = 2'b11;
    tick();
    m_ptr = (model_win(2'b01, m_ptr, 1'b1) + 1) % NM;
    req_i[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sel_o != 0) seen_sel = 1;
      if (rvalid_o != 0) break;
    end
    ack_i = '0;
    n_chk++;
    if (seen_sel) $display("FAIL miss_sel got sel set exp never"); else n_pass++;
    n_chk++;
    if ({rvalid_o, err_o, rdata_o} !== {2'b01, 2'b01, 32'h0})
      $display("FAIL miss_resp got rv %b err %b rd %h exp 01/01/0", rvalid_o, err_o, rdata_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit late = 0;
    set_req(1, 32'h1004, 1'b0, 32'h0, 4'hF);
    rdata_i[1] = 32'h1234_5678;
    tick();
    n_chk++;
    if (gnt_o !== 2'b10) $display("FAIL to_gnt got %b exp 10", gnt_o); else n_pass++;
    m_ptr = (model_win(2'b10, m_ptr, 1'b1) + 1) % NM;
    req_i[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sel_o == 2'b10) hi++;
      if (rvalid_o != 0) break;
    end
    n_chk++;
    if (hi != TMO + 1) $display("FAIL to_sel_cycles got %0d exp %0d", hi, TMO + 1); else n_pass++;
    n_chk++;
    if ({rvalid_o, err_o, rdata_o, sel_o} !== {2'b10, 2'b10, 32'h0, 2'b00})
      $display("FAIL to_resp got rv %b err %b rd %h sel %b exp 10/10/0/00", rvalid_o, err_o, rdata_o, sel_o);
    else n_pass++;
    ack_i[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rvalid_o != 0 || sel_o != 0) late = 1;
    end
    ack_i = '0;
    n_chk++;
    if (late) $display("FAIL to_late_ack got activity exp none"); else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    set_req(0, 32'h200, 1'b0, 32'h0, 4'hF);
    rdata_i[0] = 32'hCAFE_F00D;
    tick();
    m_ptr = (model_win(2'b01, m_ptr, 1'b1) + 1) % NM;
    req_i[0] = 1'b0;
    tick();
    for (int k = 0; k < TMO; k++) tick();
    n_chk++;
    if (sel_o !== 2'b01) $display("FAIL tie_sel got %b exp 01", sel_o); else n_pass++;
    ack_i[0] = 1'b1;
    tick();
    ack_i = '0;
    n_chk++;
    if ({rvalid_o, err_o, rdata_o} !== {2'b01, 2'b00, 32'hCAFE_F00D})
      $display("FAIL tie_resp got rv %b err %b rd %h exp 01/00/cafef00d", rvalid_o, err_o, rdata_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_in_wait();
    bit ghost = 0;
    int w;
    set_req(0, 32'h300, 1'b1, 32'hABCD_0123, 4'hC);
    tick();
    m_ptr = (model_win(2'b01, m_ptr, 1'b1) + 1) % NM;
    req_i[0] = 1'b0;
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({gnt_o, rvalid_o, err_o, sel_o, we_o, rdata_o, addr_o, wdata_o, be_o} !== '0)
      $display("FAIL rstw_outputs got sel %b addr %h we %b exp all 0", sel_o, addr_o, we_o);
    else n_pass++;
    m_ptr = 0;
    tick();
    rst_ni = 1'b1;
    ack_i = 2'b11;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rvalid_o != 0) ghost = 1;
    end
    n_chk++;
    if (ghost) $display("FAIL rstw_ghost got rvalid exp none"); else n_pass++;
    set_req(0, 32'h400, 1'b0, 32'h0, 4'hF);
    set_req(1, 32'h1008, 1'b1, 32'h0BAD_CAFE, 4'h1);
    w = model_win(2'b11, m_ptr, 1'b1);
    m_ptr = (w + 1) % NM;
    tick();
    n_chk++;
    if (gnt_o !== oh(w)) $display("FAIL rstw_gnt got %b exp %b", gnt_o, oh(w)); else n_pass++;
    req_i[w] = 1'b0;
    w = model_win(req_i, m_ptr, 1'b1);
    m_ptr = (w + 1) % NM;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (gnt_o != 0) break;
    end
    n_chk++;
    if (gnt_o !== oh(w)) $display("FAIL rstw_held_gnt got %b exp %b", gnt_o, oh(w)); else n_pass++;
    req_i = '0;
    tick(); tick(); tick(); tick();
    ack_i = '0;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int w, es, d, kd, ek;
      bit ok;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, rd;
      logic ewe;
      logic [BW-1:0] ebe;
      for (int m = 0; m < NM; m++) begin
        if (!req_i[m] && ($urandom % 2 == 0)) begin
          int r;
          r = int'($urandom % 3);
          set_req(m, (r == 0) ? {20'h0, 12'($urandom)} : (r == 1) ? {20'h1, 12'($urandom)} : 32'hF000_0000 | 32'($urandom % 256),
                  1'($urandom), $urandom, 4'($urandom));
        end
      end
      if (req_i == 0) set_req(int'($urandom % NM), 32'h0000_0010, 1'b0, 32'h0, 4'hF);
      w = model_win(req_i, m_ptr, 1'b1);
      ea = addr_i[w]; ewd = wdata_i[w]; ewe = we_i[w]; ebe = be_i[w];
      tick();
      n_chk++;
      if (gnt_o !== oh(w)) $display("FAIL rnd_gnt it%0d got %b exp %b", it, gnt_o, oh(w)); else n_pass++;
      m_ptr = (w + 1) % NM;
      req_i[w] = 1'b0;
      es = model_slave(ea);
      tick();
      if (es < 0) begin
        n_chk++;
        if ({sel_o, rvalid_o, err_o, rdata_o} !== {2'b00, oh(w), oh(w), 32'h0})
          $display("FAIL rnd_miss it%0d got sel %b rv %b err %b rd %h", it, sel_o, rvalid_o, err_o, rdata_o);
        else n_pass++;
      end else begin
        n_chk++;
        if ({sel_o, addr_o, we_o, wdata_o, be_o} !== {oh(es), ea, ewe, ewe ? ewd : 32'h0, ebe})
          $display("FAIL rnd_bus it%0d got sel %b addr %h we %b wd %h be %h exp sel %b addr %h", it, sel_o, addr_o, we_o, wdata_o, be_o, oh(es), ea);
        else n_pass++;
        d = int'($urandom_range(0, 11));
        rd = $urandom;
        rdata_i[es] = rd;
        rdata_i[1 - es] = $urandom;
        kd = -1;
        for (int k = 0; k < 12; k++) begin
          ack_i = '0;
          if (k == d) ack_i[es] = 1'b1;
          ack_i[1 - es] = 1'($urandom);
          tick();
          ack_i = '0;
          if (rvalid_o != 0) begin kd = k; break; end
        end
        ok = (d <= TMO);
        ek = ok ? d : TMO;
        n_chk++;
        if (kd != ek) $display("FAIL rnd_latency it%0d got %0d exp %0d", it, kd, ek); else n_pass++;
        n_chk++;
        if ({rvalid_o, err_o, rdata_o, sel_o} !== {oh(w), ok ? 2'b00 : oh(w), (ok && !ewe) ? rd : 32'h0, 2'b00})
          $display("FAIL rnd_resp it%0d got rv %b err %b rd %h sel %b", it, rvalid_o, err_o, rdata_o, sel_o);
        else n_pass++;
      end
      tick();
      n_chk++;
      if (rvalid_o !== 2'b00) $display("FAIL rnd_pulse it%0d got %b exp 00", it, rvalid_o); else n_pass++;
    end
    req_i = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    n_chk = 0; n_pass = 0; m_ptr = 0;
    rst_ni = 1'b0;
    req_i = '0; addr_i = '0; wdata_i = '0; we_i = '0; be_i = '0;
    rdata_i = '0; ack_i = '0;
    test_reset();
    test_rr();
    test_single_read();
    test_miss();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
